// File: rtl/sdcram_sector_dma.sv
// Sector DMA engine between a 128x32 CPU-visible buffer and a byte-addressed
// sdcram word port. A read moves one 512-byte sector from the card into the
// buffer, and a write moves the buffer out to the card. Each word is one
// request followed by a busy handshake. A per-word wait counter aborts a stuck
// transfer and raises a sticky error flag.
module sdcram_sector_dma #(
    parameter int WAIT_LIMIT = 1024
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        i_cmd_en,
    input  logic        i_cmd_wr,
    input  logic [31:0] i_cmd_sector,
    output logic        o_cmd_busy,
    output logic        o_done,
    output logic        o_err,
    input  logic [6:0]  i_buf_addr,
    input  logic        i_buf_we,
    input  logic [31:0] i_buf_wdata,
    output logic [31:0] o_buf_rdata,
    output logic [40:0] o_sdcram_addr,
    output logic        o_sdcram_ren,
    output logic [3:0]  o_sdcram_wen,
    output logic [31:0] o_sdcram_wdata,
    input  logic [31:0] i_sdcram_rdata,
    input  logic        i_sdcram_busy
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_sector;
    logic            r_wr;
    logic [6:0]      r_idx;
    logic            r_seen;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_done;
    logic            r_err;
    logic [31:0]     r_wdata;
    logic [31:0]     r_buf [128];
    logic [31:0]     r_buf_rdata;

    logic            w_accept;
    logic            w_launch;
    logic            w_word_done;
    logic            w_timeout;
    logic            w_last;
    logic            w_buf_eng_we;
    logic            w_buf_cpu_we;

    // Byte address of a word inside a sector; 41 bits, so no carry can escape.
    function automatic logic [40:0] word_addr(input logic [31:0] sector, input logic [6:0] idx);
        return {sector, idx, 2'b00};
    endfunction

    assign w_accept     = (r_state == S_IDLE) && i_cmd_en;
    assign w_launch     = (r_state == S_ISSUE) && !i_sdcram_busy;
    assign w_word_done  = (r_state == S_WAIT) && r_seen && !i_sdcram_busy;
    assign w_timeout    = (r_state == S_WAIT) && !w_word_done && (r_wait_cnt == CW'(WAIT_LIMIT - 1));
    assign w_last       = (r_idx == 7'd127);
    assign w_buf_eng_we = w_word_done && !r_wr;
    assign w_buf_cpu_we = (r_state == S_IDLE) && i_buf_we;

    // Requests exist only in the launching ISSUE cycle, so they fall with reset at once.
    assign o_sdcram_ren   = w_launch && !r_wr;
    assign o_sdcram_wen   = (w_launch && r_wr) ? 4'hF : 4'h0;
    assign o_sdcram_addr  = word_addr(r_sector, r_idx);
    assign o_sdcram_wdata = r_wdata;
    assign o_cmd_busy     = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_buf_rdata    = r_buf_rdata;

    // Next-state selection for the word sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_en) begin
                    w_state_nxt = i_cmd_wr ? S_LOAD : S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_launch) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (w_word_done) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = r_wr ? S_LOAD : S_ISSUE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch, word index, handshake tracking, status flags and write data.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_sector   <= 32'd0;
            r_wr       <= 1'b0;
            r_idx      <= 7'd0;
            r_seen     <= 1'b0;
            r_wait_cnt <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sector <= i_cmd_sector;
                r_wr     <= i_cmd_wr;
                r_idx    <= 7'd0;
                r_err    <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_wdata <= r_buf[r_idx];
            end
            if (w_launch) begin
                r_seen     <= 1'b0;
                r_wait_cnt <= '0;
            end
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
                if (i_sdcram_busy) begin
                    r_seen <= 1'b1;
                end
                if (w_word_done) begin
                    if (w_last) begin
                        r_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 7'd1;
                    end
                end else if (w_timeout) begin
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Sector buffer: engine write-back has priority; CPU writes land only when idle.
    always_ff @(posedge CLK) begin
        if (w_buf_eng_we) begin
            r_buf[r_idx] <= i_sdcram_rdata;
        end else if (w_buf_cpu_we) begin
            r_buf[i_buf_addr] <= i_buf_wdata;
        end
        r_buf_rdata <= r_buf[i_buf_addr];
    end

endmodule
